// File: rtl/imm_extend_stage.sv
// Decode-stage immediate generator (I/B/CB/D/IW) feeding a 2-entry in-order skid buffer.
// Latency: 1 cycle from accept to out_valid when empty; sustains 1 result/cycle.
// Backpressure: in_ready drops when both entries are held; the head entry holds stable while out_ready is low.

module skid_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          wr_vld_i,
    output logic          wr_rdy_o,
    input  logic [DW-1:0] wr_dat_i,
    output logic          rd_vld_o,
    input  logic          rd_rdy_i,
    output logic [DW-1:0] rd_dat_o,
    output logic [1:0]    count_o
);
    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          rdy_en_q;
    logic          push;
    logic          pop;

    // rdy_en_q keeps the write side closed until the first clock after reset releases.
    assign wr_rdy_o = rdy_en_q & (occ_q != 2'd2);
    assign rd_vld_o = (occ_q != 2'd0);
    assign rd_dat_o = head_q;
    assign count_o  = occ_q;
    assign push     = wr_vld_i & wr_rdy_o;
    assign pop      = rd_vld_o & rd_rdy_i;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush_i) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b11: head_d = wr_dat_i;  // only reachable at occupancy 1
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = wr_dat_i;
                    end else begin
                        tail_d = wr_dat_i;
                    end
                    occ_d = occ_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q    <= 2'd0;
            head_q   <= '0;
            tail_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            rdy_en_q <= 1'b1;
        end
    end
endmodule

module imm_extend_stage #(
    parameter int WIDTH    = 64,
    parameter int BR_SCALE = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [2:0]       fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] extended,
    output logic [TAG_W-1:0] out_tag,
    output logic             err,
    output logic [1:0]       occupancy
);
    typedef struct packed {
        logic [WIDTH-1:0] imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    localparam int         BR_SH   = (BR_SCALE != 0) ? 2 : 0;
    localparam logic [6:0] WIDTH_L = 7'(WIDTH);

    logic [63:0] ext64;
    logic        ext_err;
    logic [6:0]  iw_top;
    entry_t      wr_ent;
    entry_t      rd_ent;
    logic        unused_bits;

    assign unused_bits = ^{instruction[31:26], instruction[4:0]};

    // Everything is built at 64 bits and truncated afterwards so every format shares one path.
    always_comb begin
        ext64   = '0;
        ext_err = 1'b0;
        iw_top  = {1'b0, instruction[22:21], 4'b0000} + 7'd16;
        case (fmt)
            3'b000: ext64 = {52'b0, instruction[21:10]};
            3'b001: ext64 = {{38{instruction[25]}}, instruction[25:0]} << BR_SH;
            3'b010: ext64 = {{45{instruction[23]}}, instruction[23:5]} << BR_SH;
            3'b011: ext64 = {{55{instruction[20]}}, instruction[20:12]};
            3'b100: begin
                if (iw_top > WIDTH_L) begin
                    ext_err = 1'b1;
                end else begin
                    ext64 = {48'b0, instruction[20:5]} << {instruction[22:21], 4'b0000};
                end
            end
            default: ext_err = 1'b1;
        endcase
    end

    always_comb begin
        wr_ent.imm = ext64[WIDTH-1:0];
        wr_ent.tag = in_tag;
        wr_ent.err = ext_err;
    end

    skid_fifo2 #(
        .DW($bits(entry_t))
    ) u_buf (
        .clk      (clk),
        .rst      (reset),
        .flush_i  (flush),
        .wr_vld_i (in_valid),
        .wr_rdy_o (in_ready),
        .wr_dat_i (wr_ent),
        .rd_vld_o (out_valid),
        .rd_rdy_i (out_ready),
        .rd_dat_o (rd_ent),
        .count_o  (occupancy)
    );

    assign extended = rd_ent.imm;
    assign out_tag  = rd_ent.tag;
    assign err      = rd_ent.err;
endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: WIDTH=64/BR_SCALE=1 and WIDTH=32/BR_SCALE=0 instances share stimulus.
module tb_imm_extend_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instruction = '0;
    logic [2:0]  fmt = '0;
    logic [4:0]  in_tag = '0;

    logic        in_ready_a, out_valid_a, err_a;
    logic [63:0] ext_a;
    logic [4:0]  tag_a;
    logic [1:0]  occ_a;
    logic        in_ready_b, out_valid_b, err_b;
    logic [31:0] ext_b;
    logic [4:0]  tag_b;
    logic [1:0]  occ_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  f;
        logic [63:0] ea;
        logic        eea;
        logic [31:0] eb;
        logic        eeb;
    } vec_t;

    exp_t       qa[$];
    exp_t       qb[$];
    bit         m_ren = 1'b0;
    logic [4:0] log_q[$];
    vec_t       vt[9];

    always #5 clk = ~clk;

    imm_extend_stage #(.WIDTH(64), .BR_SCALE(1), .TAG_W(5)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .instruction(instruction), .fmt(fmt), .in_tag(in_tag), .out_valid(out_valid_a),
        .out_ready(out_ready), .extended(ext_a), .out_tag(tag_a), .err(err_a), .occupancy(occ_a)
    );

    imm_extend_stage #(.WIDTH(32), .BR_SCALE(0), .TAG_W(5)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .instruction(instruction), .fmt(fmt), .in_tag(in_tag), .out_valid(out_valid_b),
        .out_ready(out_ready), .extended(ext_b), .out_tag(tag_b), .err(err_b), .occupancy(occ_b)
    );

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: signed/unsigned integer values scaled, then reduced modulo 2^w.
    function automatic logic [64:0] model_ext(input int w, input bit sc, input logic [31:0] ins,
                                              input logic [2:0] f);
        longint v;
        bit     e;
        int     hw;
        v = 0;
        e = 1'b0;
        case (f)
            3'd0: v = longint'(ins[21:10]);
            3'd1: v = longint'($signed(ins[25:0])) * (sc ? 4 : 1);
            3'd2: v = longint'($signed(ins[23:5])) * (sc ? 4 : 1);
            3'd3: v = longint'($signed(ins[20:12]));
            3'd4: begin
                hw = int'(ins[22:21]);
                if (16 * hw + 16 > w) e = 1'b1;
                else v = longint'(ins[20:5]) * (longint'(1) << (16 * hw));
            end
            default: e = 1'b1;
        endcase
        if (w < 64) v = v & ((longint'(1) << w) - 1);
        return {e, 64'(v)};
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [64:0] ra;
        logic [64:0] rb;
        bit acc;
        bit pop;
        if (reset) begin
            m_ren = 1'b0;
            qa.delete();
            qb.delete();
        end else begin
            acc = in_valid && m_ren && (qa.size() < 2);
            pop = out_ready && (qa.size() > 0);
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (pop) begin
                    void'(qa.pop_front());
                    void'(qb.pop_front());
                end
                if (acc) begin
                    ra = model_ext(64, 1'b1, instruction, fmt);
                    rb = model_ext(32, 1'b0, instruction, fmt);
                    qa.push_back('{ra[63:0], in_tag, ra[64]});
                    qb.push_back('{rb[63:0], in_tag, rb[64]});
                end
            end
            m_ren = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready_a", in_ready_a, m_ren && (qa.size() < 2));
        chk("in_ready_b", in_ready_b, m_ren && (qb.size() < 2));
        chk("occ_a", occ_a, qa.size());
        chk("occ_b", occ_b, qb.size());
        chk("out_valid_a", out_valid_a, qa.size() > 0);
        chk("out_valid_b", out_valid_b, qb.size() > 0);
        if (qa.size() > 0) begin
            chk("ext_a", ext_a, qa[0].imm);
            chk("tag_a", tag_a, qa[0].tag);
            chk("err_a", err_a, qa[0].err);
        end
        if (qb.size() > 0) begin
            chk("ext_b", ext_b, qb[0].imm);
            chk("tag_b", tag_b, qb[0].tag);
            chk("err_b", err_b, qb[0].err);
        end
    end

    always @(posedge clk) begin
        if (!reset && !flush && out_valid_a && out_ready) log_q.push_back(tag_a);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [2:0] f,
                         input logic [4:0] t);
        in_valid    = v;
        instruction = ins;
        fmt         = f;
        in_tag      = t;
    endtask

    task automatic send(input int idx, input logic [4:0] t);
        bit ok;
        ok = 1'b0;
        offer(1'b1, vt[idx].ins, vt[idx].f, t);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ok = in_ready_a;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk("send_timeout", 65'd0, 65'd1);
        offer(1'b0, '0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h03FFFFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vt[1] = '{32'h003FFC00, 3'd0, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0};
        vt[2] = '{32'h0057DDE0, 3'd4, 64'h0000_BEEF_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vt[3] = '{32'h0057DDE0, 3'd6, 64'h0000_0000_0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vt[4] = '{32'h00800000, 3'd2, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 32'hFFFC_0000, 1'b0};
        vt[5] = '{32'h00100000, 3'd3, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 32'hFFFF_FF00, 1'b0};
        vt[6] = '{32'h0037DDE0, 3'd4, 64'h0000_0000_BEEF_0000, 1'b0, 32'hBEEF_0000, 1'b0};
        vt[7] = '{32'h0077DDE0, 3'd4, 64'hBEEF_0000_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vt[8] = '{32'h01FFFFFF, 3'd1, 64'h0000_0000_07FF_FFFC, 1'b0, 32'h01FF_FFFF, 1'b0};

        reset = 1'b1;
        repeat (2) step();
        chk("rst_out_valid", out_valid_a, 65'd0);
        chk("rst_occ", occ_a, 65'd0);
        chk("rst_ext", ext_a, 65'd0);
        chk("rst_err", err_a, 65'd0);
        chk("rst_in_ready", in_ready_a, 65'd0);

        chk("model_b", model_ext(64, 1'b1, 32'h03FFFFFF, 3'd1), {1'b0, 64'hFFFF_FFFF_FFFF_FFFC});
        chk("model_iw32", model_ext(32, 1'b0, 32'h0057DDE0, 3'd4), {1'b1, 64'h0});
        chk("model_cb", model_ext(64, 1'b1, 32'h00800000, 3'd2), {1'b0, 64'hFFFF_FFFF_FFF0_0000});
        chk("model_d32", model_ext(32, 1'b0, 32'h00100000, 3'd3), {1'b0, 64'h0000_0000_FFFF_FF00});
        chk("model_iw3", model_ext(64, 1'b1, 32'h0077DDE0, 3'd4), {1'b0, 64'hBEEF_0000_0000_0000});

        reset = 1'b0;
        #1;
        chk("ready_held_after_release", in_ready_a, 65'd0);
        step();
        chk("ready_after_clock", in_ready_a, 65'd1);

        // Directed formats streamed back to back.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            offer(1'b1, vt[i].ins, vt[i].f, 5'(i));
            step();
            chk($sformatf("vec%0d_valid", i), out_valid_a, 65'd1);
            chk($sformatf("vec%0d_ext_a", i), ext_a, vt[i].ea);
            chk($sformatf("vec%0d_err_a", i), err_a, vt[i].eea);
            chk($sformatf("vec%0d_ext_b", i), ext_b, vt[i].eb);
            chk($sformatf("vec%0d_err_b", i), err_b, vt[i].eeb);
        end
        offer(1'b0, '0, '0, '0);
        step();

        // Backpressure: tags 3 and 4 are refused while full and re-offered afterwards.
        out_ready = 1'b0;
        log_q.delete();
        for (int t = 1; t <= 4; t++) begin
            offer(1'b1, vt[t].ins, vt[t].f, 5'(t));
            step();
        end
        offer(1'b0, '0, '0, '0);
        chk("bp_occ", occ_a, 65'd2);
        chk("bp_ready", in_ready_a, 65'd0);
        chk("bp_head_tag", tag_a, 65'd1);
        step();
        chk("bp_hold_tag", tag_a, 65'd1);
        chk("bp_hold_ext", ext_a, vt[1].ea);
        out_ready = 1'b1;
        send(3, 5'd3);
        send(4, 5'd4);
        repeat (4) step();
        chk("bp_count", log_q.size(), 65'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk($sformatf("bp_order%0d", i), log_q[i], i + 1);

        // Streaming at full rate.
        log_q.delete();
        for (int i = 0; i < 10; i++) begin
            offer(1'b1, vt[i % 9].ins, vt[i % 9].f, 5'(i));
            step();
            chk($sformatf("stream_occ%0d", i), occ_a, 65'd1);
        end
        offer(1'b0, '0, '0, '0);
        step();
        chk("stream_count", log_q.size(), 65'd10);
        for (int i = 0; i < 10 && i < log_q.size(); i++) chk($sformatf("stream_order%0d", i), log_q[i], i);

        // Flush at occupancy 2, then at occupancy 1 with an accept in the flush cycle.
        out_ready = 1'b0;
        offer(1'b1, vt[0].ins, vt[0].f, 5'd5);
        step();
        offer(1'b1, vt[1].ins, vt[1].f, 5'd6);
        step();
        chk("fl_full", occ_a, 65'd2);
        flush = 1'b1;
        offer(1'b1, vt[2].ins, vt[2].f, 5'd7);
        step();
        flush = 1'b0;
        offer(1'b0, '0, '0, '0);
        chk("fl_valid", out_valid_a, 65'd0);
        chk("fl_occ", occ_a, 65'd0);
        chk("fl_ready", in_ready_a, 65'd1);
        offer(1'b1, vt[4].ins, vt[4].f, 5'd8);
        step();
        flush = 1'b1;
        offer(1'b1, vt[5].ins, vt[5].f, 5'd9);
        step();
        flush = 1'b0;
        offer(1'b0, '0, '0, '0);
        chk("fl1_occ", occ_a, 65'd0);
        offer(1'b1, vt[6].ins, vt[6].f, 5'd10);
        step();
        offer(1'b0, '0, '0, '0);
        chk("fl_next_valid", out_valid_a, 65'd1);
        chk("fl_next_tag", tag_a, 65'd10);
        out_ready = 1'b1;
        step();

        // Asynchronous reset between edges with the buffer full.
        out_ready = 1'b0;
        offer(1'b1, vt[0].ins, vt[0].f, 5'd11);
        step();
        offer(1'b1, vt[7].ins, vt[7].f, 5'd12);
        step();
        offer(1'b0, '0, '0, '0);
        chk("ar_full", occ_a, 65'd2);
        #1 reset = 1'b1;
        #1;
        chk("ar_valid", out_valid_a, 65'd0);
        chk("ar_occ", occ_a, 65'd0);
        chk("ar_ext", ext_a, 65'd0);
        chk("ar_err", err_a, 65'd0);
        chk("ar_ready", in_ready_a, 65'd0);
        chk("ar_ext_b", ext_b, 65'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("ar_ready_release", in_ready_a, 65'd0);
        step();
        chk("ar_ready_clock", in_ready_a, 65'd1);
        out_ready = 1'b1;
        offer(1'b1, vt[8].ins, vt[8].f, 5'd13);
        step();
        offer(1'b0, '0, '0, '0);
        chk("ar_resume_tag", tag_a, 65'd13);
        chk("ar_resume_ext", ext_a, vt[8].ea);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
